// File: rtl/log2_seq_if.sv
// log2_seq_if: start/done handshake, operand and result bundle for log2_seq.
`default_nettype none

interface log2_seq_if #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
);
  localparam int INT_W = $clog2(DATA_W);

  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [INT_W-1:0]  int_o;
  logic [FRAC_W-1:0] frac_o;

  modport master (
    output start_i, data_i,
    input  busy_o, done_o, err_o, int_o, frac_o
  );

  modport slave (
    input  start_i, data_i,
    output busy_o, done_o, err_o, int_o, frac_o
  );
endinterface

`default_nettype wire

// File: rtl/log2_seq.sv
// ============================================================================
//  log2_seq : sequential base-2 logarithm (normalise, then square per frac bit)
//  Optional macro LOG2_SEQ_ROUND_EN: one guard bit, round-to-nearest frac_o.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module log2_seq #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter int MANT_W = 16,
  parameter int INT_W  = $clog2(DATA_W)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  log2_seq_if.slave   bus
);

`ifdef LOG2_SEQ_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif
  localparam int ACC_W = FRAC_W + GUARD;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [INT_W-1:0] TOP_IDX  = INT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_FRAC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] shreg;
  logic [INT_W-1:0]  lz_cnt;
  logic [INT_W-1:0]  int_work;
  logic [MANT_W-1:0] mant;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ACC_W-1:0]  acc;
  logic [INT_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic              err_q;

  logic              accept;
  logic              data_zero;
  logic [MANT_W:0]   sq_top;
  logic [MANT_W-1:0] mant_nxt;
  logic [ACC_W-1:0]  acc_nxt;
  logic [FRAC_W-1:0] frac_fin;

  assign accept    = bus.start_i && ((state == S_IDLE) || (state == S_DONE));
  assign data_zero = (bus.data_i == '0);

  // Keep only square bits 2*MANT_W-1 .. MANT_W-1; lower bits never reach the mantissa.
  assign sq_top   = (MANT_W+1)'(({{MANT_W{1'b0}}, mant} * {{MANT_W{1'b0}}, mant}) >> (MANT_W - 1));
  assign mant_nxt = sq_top[MANT_W] ? sq_top[MANT_W:1] : sq_top[MANT_W-1:0];
  assign acc_nxt  = ACC_W'({acc, sq_top[MANT_W]});

`ifdef LOG2_SEQ_ROUND_EN
  logic [FRAC_W:0] rnd_sum;
  assign rnd_sum  = {1'b0, acc_nxt[ACC_W-1:1]} + {{FRAC_W{1'b0}}, acc_nxt[0]};
  assign frac_fin = rnd_sum[FRAC_W] ? {FRAC_W{1'b1}} : rnd_sum[FRAC_W-1:0];
`else
  assign frac_fin = acc_nxt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = data_zero ? S_DONE : S_NORM;
      S_NORM: if (shreg[DATA_W-1]) state_nxt = S_FRAC;
      S_FRAC: if (bit_cnt == LAST_BIT) state_nxt = S_DONE;
      S_DONE: begin
        if (accept) state_nxt = data_zero ? S_DONE : S_NORM;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg    <= '0;
      lz_cnt   <= '0;
      int_work <= '0;
      mant     <= '0;
      bit_cnt  <= '0;
      acc      <= '0;
      int_q    <= '0;
      frac_q   <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (data_zero) begin
        err_q  <= 1'b1;
        int_q  <= '0;
        frac_q <= '0;
      end else begin
        shreg  <= bus.data_i;
        lz_cnt <= '0;
        err_q  <= 1'b0;
        acc    <= '0;
      end
    end else begin
      case (state)
        S_NORM: begin
          if (!shreg[DATA_W-1]) begin
            shreg  <= shreg << 1;
            lz_cnt <= lz_cnt + 1'b1;
          end else begin
            int_work <= TOP_IDX - lz_cnt;
            mant     <= shreg[DATA_W-1 -: MANT_W];
            bit_cnt  <= '0;
          end
        end
        S_FRAC: begin
          acc     <= acc_nxt;
          mant    <= mant_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            int_q  <= int_work;
            frac_q <= frac_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (state == S_NORM) || (state == S_FRAC);
  assign bus.done_o = (state == S_DONE);
  assign bus.err_o  = err_q;
  assign bus.int_o  = int_q;
  assign bus.frac_o = frac_q;

endmodule

`default_nettype wire

// File: tb/tb_log2_seq.sv
// tb_log2_seq: directed vectors with hand-computed log2 results and latencies.
`default_nettype none

module tb_log2_seq;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 8;
  localparam int MANT_W = 16;
`ifdef LOG2_SEQ_ROUND_EN
  localparam int XL = 1;
  localparam int F3 = 'h96;
  localparam int F7 = 'hCF;
`else
  localparam int XL = 0;
  localparam int F3 = 'h95;
  localparam int F7 = 'hCE;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  log2_seq_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) bus ();

  log2_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .MANT_W(MANT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] d);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.data_i  = d;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Called on the first negedge after the accept edge (cycle 1).
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int k = 1; k <= 200; k++) begin
      if (bus.done_o) begin
        lat = k;
        break;
      end
      if (bus.busy_o) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] d, input int e_lat,
                     input int e_int, input int e_frac, input int e_err);
    int lat, bn;
    launch(d);
    wait_done(lat, bn);
    chk({tag, ".lat"},  lat,        e_lat);
    chk({tag, ".int"},  bus.int_o,  e_int);
    chk({tag, ".frac"}, bus.frac_o, e_frac);
    chk({tag, ".err"},  bus.err_o,  e_err);
    @(negedge clk);
    chk({tag, ".pulse"}, bus.done_o, 0);
  endtask

  initial begin
    int lat, bn, dones;
    bus.start_i = 1'b0;
    bus.data_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", bus.busy_o, 0);
    chk("rst.done", bus.done_o, 0);
    chk("rst.err",  bus.err_o,  0);
    chk("rst.int",  bus.int_o,  0);
    chk("rst.frac", bus.frac_o, 0);
    rst = 1'b0;

    launch(32'h1);
    wait_done(lat, bn);
    chk("one.busy", bn,         40 + XL);
    chk("one.lat",  lat,        41 + XL);
    chk("one.int",  bus.int_o,  0);
    chk("one.frac", bus.frac_o, 0);
    chk("one.err",  bus.err_o,  0);

    run("msb",   32'h8000_0000, 10 + XL, 31, 0,    0);
    run("three", 32'd3,         40 + XL, 1,  F3,   0);
    run("ten",   32'd10,        38 + XL, 3,  'h52, 0);
    run("zero",  32'd0,         1,       0,  0,    1);
    chk("zero.hold", bus.err_o, 1);
    run("two",   32'd2,         40 + XL, 1,  0,    0);

    // start held high with other data while busy, then accepted in the DONE cycle
    launch(32'd5);
    bus.start_i = 1'b1;
    bus.data_i  = 32'd7;
    wait_done(lat, bn);
    chk("hold.lat",  lat,        39 + XL);
    chk("hold.int",  bus.int_o,  2);
    chk("hold.frac", bus.frac_o, 'h52);
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("b2b.busy", bus.busy_o, 1);
    chk("b2b.done", bus.done_o, 0);
    wait_done(lat, bn);
    chk("b2b.lat",  lat,        39 + XL);
    chk("b2b.int",  bus.int_o,  2);
    chk("b2b.frac", bus.frac_o, F7);

    // abort in the middle of FRAC
    launch(32'h00FF_FFFF);
    repeat (12) @(negedge clk);
    chk("mid.busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    chk("abort.busy", bus.busy_o, 0);
    chk("abort.done", bus.done_o, 0);
    chk("abort.err",  bus.err_o,  0);
    chk("abort.int",  bus.int_o,  0);
    chk("abort.frac", bus.frac_o, 0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    chk("abort.nodone", dones, 0);
    run("after_rst", 32'h100, 33 + XL, 8, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/log2_seq.md
Name: log2_seq

Overview:
- Parametrised sequential base-2 logarithm unit for the log-base-2 design.
- Takes an unsigned DATA_W-bit operand under a start/done handshake.
- Normalises the operand one bit per cycle to get the integer part floor(log2 x).
- Produces FRAC_W fractional bits, one bit per cycle, by repeated squaring of the normalised mantissa.
- Zero operands are flagged as an error.

Parameters:
- DATA_W, 32, operand width in bits (>= 2).
- FRAC_W, 8, number of fractional result bits.
- MANT_W, 16, mantissa width in bits, format Q1.(MANT_W-1); MANT_W <= DATA_W.
- INT_W, $clog2(DATA_W), integer result width (derived; do not override).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  request; sampled only when the block is accepting.
- data_i  in  DATA_W  unsigned operand; sampled in the start-accept cycle.
- busy_o  out  1  high in NORM and FRAC states.
- done_o  out  1  one-cycle pulse; result valid.
- err_o  out  1  operand was zero; valid with done_o and held after.
- int_o  out  INT_W  floor(log2 x).
- frac_o  out  FRAC_W  fractional bits of log2 x, truncated; MSB weight is 2^-1.

Behaviour:
- Reset: state IDLE. busy_o, done_o, err_o, int_o, frac_o, and all internal registers are 0. Asserting rst_i mid-operation aborts immediately; no done_o is produced.
- States: IDLE, NORM, FRAC, DONE. The block accepts start_i in IDLE or DONE and ignores it in NORM and FRAC; no queuing.
- Accept, data_i != 0:
  - Load shift register with data_i.
  - Set lz counter to 0, err to 0.
  - Clear frac register; go to NORM.
- Accept, data_i == 0:
  - Set err to 1; int and frac to 0.
  - Go directly to DONE; done_o is high in the next cycle.
- NORM, per cycle:
  - If shift register MSB is 0: shift left by 1, lz += 1.
  - Else: int = DATA_W-1-lz; mantissa = top MANT_W bits of the shift register; bit counter = 0; go to FRAC.
- FRAC, per cycle:
  - sq = mantissa*mantissa, 2*MANT_W bits, format Q2.(2*MANT_W-2).
  - If sq[2*MANT_W-1] is 1: next frac bit = 1, mantissa = sq[2*MANT_W-1 -: MANT_W].
  - Else: next frac bit = 0, mantissa = sq[2*MANT_W-2 -: MANT_W].
  - Frac bits shift in from the LSB, MSB-first order.
  - After FRAC_W bits, go to DONE.
- DONE:
  - done_o = 1 for exactly one cycle.
  - int_o, frac_o, and err_o update on entry to DONE and hold until the next accepted start.
  - Next state is IDLE, or NORM/DONE if start_i is accepted in this cycle (back-to-back operation).
- Latency, from the accept edge to the cycle where done_o is high: lz + FRAC_W + 2 cycles.
  - Minimum: FRAC_W + 2 (data_i MSB set).
  - Maximum: DATA_W + FRAC_W + 1 (data_i = 1).
  - Zero operand: 1 cycle.
- Outputs are registered; no combinational path from data_i or start_i to any output.
- Truncation error is below 1 LSB of frac_o for MANT_W >= FRAC_W+8.

Optional Feature:
- Macro: LOG2_SEQ_ROUND_EN.
- Defined:
  - FRAC runs FRAC_W+1 cycles; the extra guard bit rounds frac_o to nearest.
  - If the rounded value would exceed all-ones, frac_o saturates at all-ones; int_o is unchanged.
  - All latencies grow by 1 cycle.
- Undefined: plain truncation as above; the guard-bit logic is absent.

Test Plan (DATA_W=32, FRAC_W=8, MANT_W=16, macro undefined unless stated):
- data_i=0x00000001, start 1 cycle -> busy_o high for 40 cycles; done_o pulse at cycle 41; int_o=0, frac_o=0x00, err_o=0.
- data_i=0x80000000 -> done_o at cycle 10; int_o=31, frac_o=0x00.
- data_i=3 -> int_o=1, frac_o=0x95. data_i=10 -> int_o=3, frac_o=0x52. With LOG2_SEQ_ROUND_EN, data_i=3 -> frac_o=0x96, one cycle later.
- data_i=0 -> done_o the next cycle with err_o=1, int_o=0, frac_o=0; next op data_i=2 -> err_o=0, int_o=1, frac_o=0x00.
- start_i held high with new data_i during busy -> ignored; first result unchanged. start_i in the DONE cycle -> new op accepted, no idle gap.
- rst_i pulsed mid-FRAC -> all outputs 0 at once, no done_o. Next start with data_i=0x100 -> int_o=8, frac_o=0x00.
